angle_normalizer: RTL and testbench
===================================

ANGLE_NORMALIZER -- requirements
Module: angle_normalizer

Interface
REQ-001 SHALL have parameter: WIDTH, 16, width of quantized angle sent to cordic (only 16 supported).
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-high:
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous active-high reset
  start  input  1  processor request; sampled only in IDLE
  angle_deg  input  16  signed angle, whole degrees (-32768..32767)
  cordic_recived  input  1  cordic has taken current angle
  angle_out  output  WIDTH  signed first-quadrant angle to cordic, 0x4000 = 45 deg
  quadrant  output  2  quadrant index 0..3 for result_converter
  valid_out  output  1  angle_out/quadrant valid to cordic
  busy  output  1  request in progress; start ignored

Function
REQ-003 SHALL implement FSM states IDLE, WRAP, FOLD, SCALE, SEND; one transition per clk edge max.
REQ-004 IDLE: on start=1, SHALL capture angle_deg sign-extended into 17-bit signed register r, clear quadrant count q, set busy=1, go WRAP; start=0 stays IDLE.
REQ-005 WRAP: if r<0, r<=r+360; else if r>=360, r<=r-360; else go FOLD; exactly one add/sub per cycle.
REQ-006 FOLD: if r>=90, r<=r-90 and q<=q+1; else go SCALE; max 3 subtracts.
REQ-007 SCALE: SHALL set angle_out <= (r*46604)>>7 (unsigned, r 0..89, 23-bit product, truncated), quadrant<=q, valid_out<=1, go SEND.
REQ-008 Quantization points: 0->0x0000, 45->0x4000 exactly, 89->0x7E94; output never negative.
REQ-009 SEND: hold valid_out, angle_out, quadrant stable until cordic_recived=1 sampled; then valid_out<=0, busy<=0, go IDLE.
REQ-010 angle_out and quadrant SHALL retain last values after SEND until next SCALE.
REQ-011 start while busy=1 SHALL be ignored, no queuing.
REQ-012 Latency: start sampled at edge N -> valid_out high after edge N+3+W+F (W = wrap ops, F = fold ops).
REQ-013 cordic_recived=1 outside SEND SHALL be ignored.
REQ-014 start and cordic_recived both high in SEND: SEND exits to IDLE; start not captured that cycle.
REQ-015 Unused state encodings SHALL go to IDLE next edge, outputs unchanged.

Reset
REQ-016 rst=1 SHALL immediately force IDLE, angle_out=0, quadrant=0, valid_out=0, busy=0, r=0, q=0, regardless of clk.
REQ-017 Reset mid-operation SHALL abandon the request; no valid_out pulse after rst release until new start.

Verification
REQ-018 start, angle_deg=0 -> after 3 edges valid_out=1, angle_out=0x0000, quadrant=0, busy=1.
REQ-019 angle_deg=135 -> 1 fold, after 4 edges angle_out=0x4000, quadrant=1.
REQ-020 angle_deg=-90 -> wrap to 270, 3 folds, after 7 edges angle_out=0x0000, quadrant=3.
REQ-021 angle_deg=400 -> wrap to 40, after 4 edges angle_out=0x38E3, quadrant=0; angle_deg=32767 -> 91 wraps to 7, angle_out=0x09F4, quadrant=0.
REQ-022 Hold cordic_recived=0 10 cycles in SEND, pulse start -> valid_out/angle_out stable, start ignored; cordic_recived=1 -> valid_out=0, busy=0 next edge, new start then accepted.
REQ-023 Assert rst during WRAP of angle_deg=-32768 -> outputs zero at once, stay IDLE after release, no valid_out.

Source files
------------

// File: rtl/angle_normalizer_if.sv
// angle_normalizer_if: request/response bundle between processor, normalizer and cordic
interface angle_normalizer_if #(parameter int WIDTH = 16);
  logic start;
  logic signed [15:0] angle_deg;
  logic cordic_recived;
  logic signed [WIDTH-1:0] angle_out;
  logic [1:0] quadrant;
  logic valid_out;
  logic busy;
  modport master(output start, angle_deg, cordic_recived, input angle_out, quadrant, valid_out, busy);
  modport slave(input start, angle_deg, cordic_recived, output angle_out, quadrant, valid_out, busy);
endinterface

// File: rtl/angle_normalizer.sv
// angle_normalizer: reduces a whole-degree angle to a first-quadrant cordic angle plus quadrant index
module angle_normalizer #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  angle_normalizer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRAP, FOLD, SCALE, SEND} state_t;
  state_t state, state_n;
  logic signed [16:0] r, r_n;
  logic [1:0] q, q_n, qd, qd_n;
  logic [WIDTH-1:0] ao, ao_n;
  logic v, v_n, b, b_n;
  logic [22:0] prod;
  // r is 0..89 in SCALE, so its low 7 bits carry the whole value
  assign prod = 23'(r[6:0]) * 23'd46604;
  assign bus.angle_out = ao;
  assign bus.quadrant = qd;
  assign bus.valid_out = v;
  assign bus.busy = b;
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      q <= '0;
      ao <= '0;
      qd <= '0;
      v <= 1'b0;
      b <= 1'b0;
    end else begin
      state <= state_n;
      r <= r_n;
      q <= q_n;
      ao <= ao_n;
      qd <= qd_n;
      v <= v_n;
      b <= b_n;
    end
  end
  // next state: one wrap or fold step per cycle, then scale and hold until cordic takes it
  always_comb begin
    state_n = state;
    r_n = r;
    q_n = q;
    ao_n = ao;
    qd_n = qd;
    v_n = v;
    b_n = b;
    case (state)
      IDLE: begin
        r_n = bus.start ? 17'(bus.angle_deg) : r;
        q_n = bus.start ? 2'd0 : q;
        b_n = bus.start ? 1'b1 : b;
        state_n = bus.start ? WRAP : IDLE;
      end
      WRAP: begin
        r_n = r < 0 ? r + 17'sd360 : r >= 17'sd360 ? r - 17'sd360 : r;
        state_n = (r < 0 || r >= 17'sd360) ? WRAP : FOLD;
      end
      FOLD: begin
        r_n = r >= 17'sd90 ? r - 17'sd90 : r;
        q_n = r >= 17'sd90 ? q + 2'd1 : q;
        state_n = r >= 17'sd90 ? FOLD : SCALE;
      end
      SCALE: begin
        ao_n = prod[22:7];
        qd_n = q;
        v_n = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        v_n = bus.cordic_recived ? 1'b0 : v;
        b_n = bus.cordic_recived ? 1'b0 : b;
        state_n = bus.cordic_recived ? IDLE : SEND;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_angle_normalizer.sv
// tb_angle_normalizer: randomized scoreboard bench for angle_normalizer
module tb_angle_normalizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {logic [15:0] ao; logic [1:0] q; int edge_n;} exp_t;
  exp_t sb[$];
  angle_normalizer_if #(.WIDTH(16)) bus();
  angle_normalizer #(.WIDTH(16)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input int a, input int n);
    exp_t e;
    int m, w;
    m = ((a % 360) + 360) % 360;
    w = a < 0 ? (-a + 359) / 360 : a / 360;
    e.ao = 16'(((m % 90) * 46604) >> 7);
    e.q = 2'(m / 90);
    e.edge_n = n + 3 + w + m / 90;
    return e;
  endfunction
  // monitor: pops an expectation on every new valid_out and checks hold/retention
  initial begin
    bit pv = 0;
    bit have = 0;
    logic [15:0] last_ao = '0;
    logic [1:0] last_q = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
        have = 0;
      end else if (bus.valid_out && !pv) begin
        if (sb.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("angle_out", int'(bus.angle_out), int'(e.ao));
          chk("quadrant", int'(bus.quadrant), int'(e.q));
          chk("latency_edge", cyc, e.edge_n);
          chk("busy_at_valid", int'(bus.busy), 1);
        end
        last_ao = bus.angle_out;
        last_q = bus.quadrant;
        have = 1;
        pv = 1;
      end else begin
        if (have) begin
          chk("angle_out_hold", int'(bus.angle_out), int'(last_ao));
          chk("quadrant_hold", int'(bus.quadrant), int'(last_q));
        end
        pv = bus.valid_out;
      end
    end
  end
  task automatic run(input int a, input bit ack_start);
    int k;
    int n;
    int hold;
    @(negedge clk);
    bus.start = 1'b1;
    bus.angle_deg = 16'(a);
    @(posedge clk);
    #1;
    n = cyc;
    bus.start = 1'b0;
    sb.push_back(model(a, n));
    @(negedge clk);
    bus.cordic_recived = 1'b1;
    @(negedge clk);
    bus.cordic_recived = 1'b0;
    k = 0;
    while (!bus.valid_out && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk("valid_timeout", 0, 1);
    hold = $urandom_range(0, 10);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.start = (i == hold / 2);
      bus.angle_deg = 16'($urandom);
    end
    @(negedge clk);
    bus.start = ack_start;
    bus.angle_deg = 16'($urandom);
    bus.cordic_recived = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cordic_recived = 1'b0;
    chk("valid_after_ack", int'(bus.valid_out), 0);
    chk("busy_after_ack", int'(bus.busy), 0);
    @(negedge clk);
    chk("busy_idle", int'(bus.busy), 0);
  endtask
  initial begin
    int dir[6] = '{0, 135, -90, 400, 32767, -32768};
    bus.start = 1'b0;
    bus.angle_deg = '0;
    bus.cordic_recived = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_angle_out", int'(bus.angle_out), 0);
    chk("rst_quadrant", int'(bus.quadrant), 0);
    chk("rst_valid", int'(bus.valid_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    foreach (dir[i]) run(dir[i], 1'b0);
    for (int i = 0; i < 40; i++) run(int'($signed(16'($urandom))), 1'($urandom_range(0, 1)));
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.angle_deg = -16'sd32768;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_angle_out", int'(bus.angle_out), 0);
    chk("mid_rst_quadrant", int'(bus.quadrant), 0);
    chk("mid_rst_valid", int'(bus.valid_out), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("post_rst_valid", int'(bus.valid_out), 0);
    chk("post_rst_busy", int'(bus.busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
